// File: rtl/axi_wr_burst_to_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_wr_pkg
// Purpose : Shared types and constants for the AXI write-burst-to-stream
//           bridge. Holds the FSM state enum, the AXI burst-type encodings
//           and the AXI write-response encodings.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package axi_wr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } wr_state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/axi_wr_burst_to_stream_if.sv
`default_nettype none
// ============================================================================
// Module  : axi_wr_burst_to_stream_if
// Purpose : Bundles the AXI4 write channels (AW/W/B) and the outgoing
//           address-tagged stream into a single interface.
// Ports   : none; modports
//             slave  - bridge view (consumes AW/W, drives B and stream)
//             master - upstream/downstream view (drives AW/W, consumes B
//                      and stream)
// Revision: 1.0 - initial release
// ============================================================================
interface axi_wr_burst_to_stream_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   s_awaddr;
  logic [7:0]          s_awlen;
  logic [2:0]          s_awsize;
  logic [1:0]          s_awburst;
  logic                s_awvalid;
  logic                s_awready;

  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_wlast;
  logic                s_wvalid;
  logic                s_wready;

  logic [1:0]          s_bresp;
  logic                s_bvalid;
  logic                s_bready;

  logic [DATA_W-1:0]   m_tdata;
  logic [DATA_W/8-1:0] m_tkeep;
  logic [ADDR_W-1:0]   m_taddr;
  logic                m_tlast;
  logic                m_tvalid;
  logic                m_tready;

  modport slave (
    input  s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
    output s_awready,
    input  s_wdata, s_wstrb, s_wlast, s_wvalid,
    output s_wready,
    output s_bresp, s_bvalid,
    input  s_bready,
    output m_tdata, m_tkeep, m_taddr, m_tlast, m_tvalid,
    input  m_tready
  );

  modport master (
    output s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
    input  s_awready,
    output s_wdata, s_wstrb, s_wlast, s_wvalid,
    input  s_wready,
    input  s_bresp, s_bvalid,
    output s_bready,
    input  m_tdata, m_tkeep, m_taddr, m_tlast, m_tvalid,
    output m_tready
  );

endinterface
`default_nettype wire

// File: rtl/axi_wr_burst_to_stream.sv
`default_nettype none
// ============================================================================
// Module  : axi_wr_burst_to_stream
// Purpose : AXI4 write-only slave that forwards each accepted W beat as a
//           stream beat tagged with its byte address, and returns one B
//           response per burst. One burst in flight at a time. Bursts that
//           are not INCR or not full-width are consumed and dropped, and
//           answered with SLVERR.
// Ports   : aclk    - clock, rising edge
//           aresetn - asynchronous active-low reset
//           bus     - AW/W/B slave channels + address-tagged stream master
// Options : AXI_WR_LEN_CHECK_EN - when defined, tracks awlen against wlast;
//           an early wlast ends the burst, a late wlast forces m_tlast on the
//           expected last beat and drops the excess; both answer SLVERR.
// Revision: 1.0 - initial release
// ============================================================================
module axi_wr_burst_to_stream
  import axi_wr_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  wire logic               aclk,
  input  wire logic               aresetn,
  axi_wr_burst_to_stream_if.slave bus
);

  localparam int                BYTES     = DATA_W / 8;
  localparam logic [2:0]        SIZE_LOG2 = 3'($clog2(BYTES));
  localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(BYTES);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_DATA = DATA;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic              r_err;
  logic              r_drop;

  logic w_in_data;
  logic w_tvalid;
  logic w_last_beat;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_bad_aw;

  assign w_in_data = (r_state == ST_DATA);
  assign w_bad_aw  = (bus.s_awburst != BURST_INCR) || (bus.s_awsize != SIZE_LOG2);

  // Normal mode is a pure combinational pass-through between W and the
  // stream; drop mode sinks W unconditionally and never presents a beat.
  assign bus.s_awready = (r_state == ST_IDLE);
  assign bus.s_wready  = w_in_data && (r_drop || bus.m_tready);
  assign w_tvalid      = w_in_data && !r_drop && bus.s_wvalid;

  assign bus.m_tvalid = w_tvalid;
  assign bus.m_tdata  = w_tvalid ? bus.s_wdata : '0;
  assign bus.m_tkeep  = w_tvalid ? bus.s_wstrb : '0;
  assign bus.m_taddr  = r_cur_addr;
  assign bus.m_tlast  = w_tvalid && w_last_beat;

  // bresp only carries the error while the response is being offered, so
  // it reads OKAY (reset value) everywhere else.
  assign bus.s_bvalid = (r_state == ST_RESP);
  assign bus.s_bresp  = (bus.s_bvalid && r_err) ? RESP_SLVERR : RESP_OKAY;

  assign w_aw_hs = bus.s_awready && bus.s_awvalid;
  assign w_w_hs  = bus.s_wready && bus.s_wvalid;
  assign w_b_hs  = bus.s_bvalid && bus.s_bready;

`ifdef AXI_WR_LEN_CHECK_EN
  logic [7:0] r_beats_left;

  // The beat with no beats left is the burst's real last beat, whatever
  // the master claims on wlast.
  assign w_last_beat = bus.s_wlast || (r_beats_left == 8'd0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_beats_left <= 8'd0;
    end else if (w_aw_hs) begin
      r_beats_left <= bus.s_awlen;
    end else if (w_w_hs && (r_beats_left != 8'd0)) begin
      r_beats_left <= r_beats_left - 8'd1;
    end
  end
`else
  logic w_unused_awlen;

  assign w_last_beat    = bus.s_wlast;
  assign w_unused_awlen = ^bus.s_awlen;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= ST_IDLE;
      r_cur_addr <= '0;
      r_err      <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_aw_hs) begin
            r_cur_addr <= bus.s_awaddr;
            r_err      <= w_bad_aw;
            r_drop     <= w_bad_aw;
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_w_hs) begin
            r_cur_addr <= r_cur_addr + ADDR_INC;
`ifdef AXI_WR_LEN_CHECK_EN
            if (!r_drop) begin
              if (bus.s_wlast && (r_beats_left != 8'd0)) begin
                r_err <= 1'b1;
              end
              // Master overran awlen: excess beats are swallowed until wlast.
              if (!bus.s_wlast && (r_beats_left == 8'd0)) begin
                r_err  <= 1'b1;
                r_drop <= 1'b1;
              end
            end
`endif
            if (bus.s_wlast) begin
              r_state <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (w_b_hs) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/axi_wr_burst_to_stream.md
# axi_wr_burst_to_stream

AXI4 write-only slave that sits directly downstream of the AXI master/passthrough path on the `aclk`/`aresetn` domain. It accepts INCR write bursts on AW/W and forwards each accepted data beat as an AXI-Stream-like beat toward the accelerator's input buffers, carrying the per-beat byte address. It returns one B response per burst. One burst is in flight at a time.

## Interface
- `ADDR_W`, default 32: AXI address width.
- `DATA_W`, default 32: data width; a power of 2 and at least 32. Bytes per beat are `DATA_W/8`.
- `aclk` in, 1: the only clock; all logic is on its rising edge.
- `aresetn` in, 1: reset, asynchronous and active-low.
- `s_awaddr` in, ADDR_W; `s_awlen` in, 8; `s_awsize` in, 3; `s_awburst` in, 2; `s_awvalid` in, 1; `s_awready` out, 1.
- `s_wdata` in, DATA_W; `s_wstrb` in, DATA_W/8; `s_wlast` in, 1; `s_wvalid` in, 1; `s_wready` out, 1.
- `s_bresp` out, 2; `s_bvalid` out, 1; `s_bready` in, 1.
- `m_tdata` out, DATA_W; `m_tkeep` out, DATA_W/8; `m_taddr` out, ADDR_W; `m_tlast` out, 1; `m_tvalid` out, 1; `m_tready` in, 1.

## Operation
- The FSM has three states: IDLE, DATA and RESP.
- **IDLE**
  - `s_awready`=1.
  - On an AW handshake: latch the address into `cur_addr`, latch `awlen` into `beats_left`, and go to DATA.
  - The error flag is set if `awburst`!=INCR(2'b01) or `awsize`!=log2(DATA_W/8). In that case the burst enters drop mode.
- **DATA, normal mode**
  - `m_tvalid`=`s_wvalid` and `s_wready`=`m_tready`. Both are combinational pass-through.
  - `m_tdata`=`s_wdata`, `m_tkeep`=`s_wstrb`, `m_taddr`=`cur_addr`, `m_tlast`=`s_wlast`.
  - On each W handshake: `cur_addr` += DATA_W/8, modulo 2^ADDR_W (wraps silently). `beats_left` decrements.
  - The beat with `s_wlast`=1 moves the FSM to RESP.
- **DATA, drop mode**
  - `s_wready`=1 and `m_tvalid`=0. Beats are consumed and discarded.
  - It exits on `s_wlast` exactly as in normal mode.
- **RESP**
  - `s_bvalid`=1. `s_bresp` is SLVERR(2'b10) if the error flag is set, else OKAY(2'b00).
  - `bresp` holds stable until the B handshake, which returns the FSM to IDLE.
- `s_awready` is 0 outside IDLE. AW is never accepted while a burst or response is pending.
- W beats presented before the AW handshake are not accepted (`s_wready`=0 in IDLE and RESP).

## Timing
- Reset values:
  - state=IDLE, `s_awready`=1, `s_wready`=0, `s_bvalid`=0, `s_bresp`=0.
  - `m_tvalid`=0, `m_tlast`=0, `m_tdata`/`m_tkeep`/`m_taddr`=0. `m_tdata` and `m_tkeep` follow the inputs but are gated to 0 when `m_tvalid`=0.
- AW handshake at edge n: DATA from n+1. The first beat can pass in cycle n+1 with zero added latency.
- Last W handshake at edge k: `s_bvalid`=1 in cycle k+1.
- B handshake at edge j: `s_awready`=1 in cycle j+1. The minimum burst overhead is 2 idle W cycles.
- Single-beat burst (`awlen`=0): the first beat carries `s_wlast`=1, so DATA lasts exactly one handshake.
- `m_tready` low stalls W with no data loss. `s_wvalid` low produces `m_tvalid` low; there are no bubbles beyond the source's.
- Reset mid-burst:
  - Immediate return to IDLE. Outputs go to their reset values asynchronously.
  - No B is issued, and any partial stream ends without `m_tlast`.
  - The downstream consumer shares `aresetn`.

## Configuration
- `AXI_WR_LEN_CHECK_EN` defined:
  - `beats_left` is compared on every beat.
  - If `s_wlast`=1 while `beats_left`!=0, or `beats_left`==0 while `s_wlast`=0, the error flag is set.
  - On an early `wlast`, the burst terminates at that beat.
  - On a late `wlast`, the remaining beats switch to drop mode until `wlast`.
  - The result is B=SLVERR. `m_tlast` is forced high on the beat where `beats_left`==0.
- Not defined: the counter logic is removed, `s_wlast` alone terminates the burst, and length mismatches are not detected.

## Structure
- Package `axi_wr_pkg`:
  - state enum `wr_state_e` {IDLE, DATA, RESP}.
  - burst constants `BURST_FIXED`/`BURST_INCR`/`BURST_WRAP`.
  - response constants `RESP_OKAY`/`RESP_SLVERR`.
- Single module. No sub-module is needed; the address/beat counter stays inline.

## Test plan
- **Single INCR burst:** `awaddr`=0x1000, `awlen`=3, `awsize`=2, data 0xA0..0xA3 → 4 stream beats with `m_taddr`=0x1000/0x1004/0x1008/0x100C, `m_tlast` on the 4th beat only, then B=OKAY one cycle after the last beat.
- **Backpressure:** toggle `m_tready` 1-0-1-0 during an `awlen`=7 burst → all 8 beats delivered in order, `s_wready` mirrors `m_tready`, no duplicates.
- **Unsupported burst:** `awburst`=WRAP, `awlen`=1 → 2 W beats consumed with `s_wready`=1 and `m_tvalid` never high, then B=SLVERR.
- **Length mismatch (macro on):** `awlen`=3 with `wlast` on the 2nd beat → 2 stream beats, `m_tlast` on the 2nd, B=SLVERR. With the macro off, the same stimulus gives B=OKAY.
- **Address wrap and back-to-back:** `awaddr`=0xFFFF_FFFC, `awlen`=1 → `m_taddr` 0xFFFF_FFFC then 0x0000_0000. An AW held valid during RESP is accepted in the cycle after the B handshake.
- **Reset mid-burst:** assert `aresetn`=0 after 2 of 4 beats → outputs at reset values immediately, no B. After release, a new burst completes with B=OKAY.
